// File: rtl/led_sched_pkg.sv
// Shared types and constants for the LED PIO write scheduler.
package led_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SRC_CPU  = 2'd0,
    SRC_ENG  = 2'd1,
    SRC_ANIM = 2'd2
  } src_t;

  localparam logic [1:0]  LED_PIO_ADDR  = 2'd0;
  localparam int unsigned LED_W_DEFAULT = 10;

endpackage

// File: rtl/led_anim_scanner.sv
// Idle scan animation: dwell-tick generator plus a bouncing one-hot position.
module led_anim_scanner #(
  parameter int unsigned LED_W        = 10,
  parameter int unsigned DWELL_CYCLES = 5_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             advance,
  output logic             anim_tick,
  output logic [LED_W-1:0] pattern
);

  localparam int unsigned CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned PW = (LED_W > 1) ? $clog2(LED_W) : 1;
  localparam logic [CW-1:0]    TICK_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [PW-1:0]    POS_LAST  = PW'(LED_W - 1);
  localparam logic [LED_W-1:0] LED_ONE   = LED_W'(1);

  logic [CW-1:0] tick_cnt;
  logic [PW-1:0] pos;
  logic          dir_down;

  assign anim_tick = enable && (tick_cnt == TICK_LAST);
  assign pattern   = LED_ONE << pos;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      pos      <= '0;
      dir_down <= 1'b0;
    end else if (clear) begin
      tick_cnt <= '0;
      pos      <= '0;
      dir_down <= 1'b0;
    end else begin
      // The counter wraps on every tick, so a tick lost to arbitration is simply dropped.
      if (enable)
        tick_cnt <= anim_tick ? '0 : tick_cnt + CW'(1);
      if (advance) begin
        if (!dir_down) begin
          if (pos == POS_LAST) begin
            dir_down <= 1'b1;
            pos      <= pos - PW'(1);
          end else begin
            pos <= pos + PW'(1);
          end
        end else begin
          if (pos == '0) begin
            dir_down <= 1'b0;
            pos      <= PW'(1);
          end else begin
            pos <= pos - PW'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/led_pio_scheduler.sv
// Avalon-MM master arbitrating CPU, engine and idle-animation writes to the LED PIO.
module led_pio_scheduler
  import led_sched_pkg::*;
#(
  parameter int unsigned LED_W        = LED_W_DEFAULT,
  parameter int unsigned HOLD_CYCLES  = 25_000_000,
  parameter int unsigned DWELL_CYCLES = 5_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cpu_req,
  input  logic [LED_W-1:0] cpu_data,
  output logic             cpu_ack,
  input  logic             eng_req,
  input  logic [LED_W-1:0] eng_data,
  output logic             eng_ack,
  input  logic             anim_en,
  output logic             m_chipselect,
  output logic             m_write_n,
  output logic [1:0]       m_address,
  output logic [31:0]      m_writedata,
  output logic [LED_W-1:0] shadow,
  output logic             busy
);

  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  state_t           state_q, state_n;
  src_t             src_q, src_n;
  logic [LED_W-1:0] wdata_q, wdata_n;
  logic [HW-1:0]    hold_q, hold_n;
  logic             anim_tick;
  logic [LED_W-1:0] anim_pattern;

  led_anim_scanner #(
    .LED_W       (LED_W),
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_scanner (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (!anim_en),
    .enable   (anim_en && (state_q == IDLE)),
    .advance  ((state_q == WRITE) && (src_q == SRC_ANIM)),
    .anim_tick(anim_tick),
    .pattern  (anim_pattern)
  );

  always_comb begin
    state_n = state_q;
    src_n   = src_q;
    wdata_n = wdata_q;
    hold_n  = hold_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          src_n = SRC_CPU;  wdata_n = cpu_data;     state_n = WRITE;
        end else if (eng_req) begin
          src_n = SRC_ENG;  wdata_n = eng_data;     state_n = WRITE;
        end else if (anim_tick) begin
          src_n = SRC_ANIM; wdata_n = anim_pattern; state_n = WRITE;
        end
      end
      WRITE: begin
        if ((src_q == SRC_ENG) && (HOLD_CYCLES > 0)) begin
          state_n = HOLD;
          hold_n  = HOLD_LOAD;
        end else begin
          state_n = IDLE;
        end
      end
      HOLD: begin
        if (cpu_req) begin
          src_n = SRC_CPU; wdata_n = cpu_data; state_n = WRITE;
        end else if (hold_q == '0) begin
          state_n = IDLE;
        end else begin
          hold_n = hold_q - HW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign m_address = LED_PIO_ADDR;

  // Bus and ack outputs are registered from the next-state decode so they align with WRITE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      src_q        <= SRC_CPU;
      wdata_q      <= '0;
      hold_q       <= '0;
      shadow       <= '0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_writedata  <= '0;
      cpu_ack      <= 1'b0;
      eng_ack      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_n;
      src_q        <= src_n;
      wdata_q      <= wdata_n;
      hold_q       <= hold_n;
      if (state_q == WRITE)
        shadow <= wdata_q;
      m_chipselect <= (state_n == WRITE);
      m_write_n    <= (state_n != WRITE);
      m_writedata  <= (state_n == WRITE) ? 32'(wdata_n) : '0;
      cpu_ack      <= (state_n == WRITE) && (src_n == SRC_CPU);
      eng_ack      <= (state_n == WRITE) && (src_n == SRC_ENG);
      busy         <= (state_n != IDLE);
    end
  end

endmodule

// File: doc/led_pio_scheduler.md
# led_pio_scheduler

Avalon-MM master that owns the write side of the 10-bit LED PIO slave and shares it among three sources: CPU override, chess-engine status, and a built-in idle scan animation. It arbitrates by fixed priority, issues single-cycle zero-wait-state writes to PIO address 0, enforces a minimum display time for engine status, and keeps a shadow copy of the LED value. It sits in the system interconnect in place of any direct master connection to the LED PIO write port.

## Interface
- LED_W, 10, LED/PIO data width
- HOLD_CYCLES, 25_000_000, minimum cycles an engine-status value stays displayed before a non-CPU write; 0 disables hold
- DWELL_CYCLES, 5_000_000, cycles between animation steps; must be ≥1
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- cpu_req  in  1  CPU write request, level, held until cpu_ack
- cpu_data  in  LED_W  CPU LED value, stable while cpu_req=1
- cpu_ack  out  1  one-cycle pulse: CPU value written
- eng_req  in  1  engine write request, level, held until eng_ack
- eng_data  in  LED_W  engine LED value, stable while eng_req=1
- eng_ack  out  1  one-cycle pulse: engine value written
- anim_en  in  1  enables idle scan animation
- m_chipselect  out  1  PIO chipselect
- m_write_n  out  1  PIO write strobe, active-low
- m_address  out  2  PIO address, always 2'd0
- m_writedata  out  32  {22'b0, value}
- shadow  out  LED_W  last value written to PIO
- busy  out  1  1 in WRITE or HOLD

## Operation
- FSM states: IDLE, WRITE, HOLD.
- IDLE: priority cpu_req > eng_req > anim_tick. Winner's data captured into a write register; next state WRITE. No request: stay.
- WRITE (exactly 1 cycle): m_chipselect=1, m_write_n=0, m_writedata={22'b0,wdata}; matching ack pulses this cycle; shadow<=wdata at cycle end. Next: HOLD if source was engine and HOLD_CYCLES>0, else IDLE.
- HOLD: counter loaded with HOLD_CYCLES−1 on entry, decrements each cycle; exit to IDLE the cycle after it reads 0 (HOLD lasts exactly HOLD_CYCLES cycles). cpu_req in HOLD preempts: capture cpu_data, go to WRITE; hold abandoned. eng_req and anim ticks wait.
- Animation: tick counter runs only while anim_en=1 and FSM in IDLE; pulses anim_tick every DWELL_CYCLES IDLE cycles, then restarts. Pattern = 1<<pos; pos starts 0, dir up; pos advances after each anim WRITE; at pos=LED_W−1 dir→down, at pos=0 dir→up (sequence 0,1,…,9,8,…,1,0,1,…). A tick that loses to a CPU/engine request is dropped, not queued; counter restarts.
- anim_en=0: pos=0, dir=up, tick counter=0 synchronously.
- A requester keeping req=1 after its ack cycle issues a new request, seen in the next IDLE cycle.
- Outside WRITE: m_chipselect=0, m_write_n=1, m_writedata=0.
- m_address constant 0.

## Timing
- Reset values: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, cpu_ack=0, eng_ack=0, shadow=0 (matches PIO reset), busy=0; FSM IDLE, pos=0, dir=up, counters 0.
- Reset asserted mid-WRITE: strobe drops immediately (async); no ack issued; requester retries.
- Latency: req seen high at IDLE cycle N → WRITE/ack at N+1 → IDLE at N+2 (non-hold). Back-to-back CPU writes: one every 2 cycles.
- CPU preempting HOLD: cpu_req at HOLD cycle N → WRITE at N+1.
- Simultaneous cpu_req and eng_req in IDLE: CPU served first; engine served at the next IDLE cycle.
- All outputs registered; no combinational path from req to ack.

## Structure
- Package led_sched_pkg: state enum (IDLE, WRITE, HOLD), source enum (SRC_CPU, SRC_ENG, SRC_ANIM), LED_PIO_ADDR=2'd0, LED_W default.
- Sub-module led_anim_scanner: tick counter, pos/dir, pattern output; inputs clk, reset_n, enable (anim_en & idle), advance (anim write done); outputs anim_tick, pattern.
- Top holds FSM, arbiter, hold counter, write register, shadow.

## Test plan
Bench uses HOLD_CYCLES=4, DWELL_CYCLES=3.
- Reset: all outputs at reset values; release, no requests → no write, shadow=0.
- cpu_req=1, cpu_data=10'h3FF at cycle N → WRITE at N+1 with m_writedata=32'h3FF, cpu_ack 1 cycle; shadow=10'h3FF; busy low at N+2.
- eng_req with 10'h155 → write; eng_req again with 10'h0AA immediately → second write exactly 4 HOLD cycles later; cpu_req 10'h001 raised in HOLD cycle 2 → written next cycle, before 10'h0AA.
- cpu_req and eng_req same cycle → CPU value written first, engine value next IDLE cycle; never both acks same cycle.
- anim_en=1, no requests → writes every 4 cycles (3 IDLE + WRITE), data 001,002,…,200,100,…,001; anim_en=0 then 1 → restarts at 001.
- Reset asserted during WRITE → m_write_n=1 same cycle, no ack; after release, held request written once.
